// File: rtl/exc_ctrl.sv
// exc_ctrl: exception sequencing controller for the LEGv8 core.
// Picks one event (NotAnInstr over IRQs, lowest IRQ index first), drains the
// pipeline for FLUSH_CYCLES, redirects fetch to the vector and records
// ELR/ESR. IRQs stay masked while the handler runs. ERet returns to ELR.
//
// Ports
//   clk, reset          clock (rising edge), synchronous active-high reset
//   irq_req [N_IRQ]     level-sensitive interrupt requests
//   irq_en              global IRQ enable
//   nai                 NotAnInstr from the main decoder
//   eret                ERet from the main decoder
//   pc [64]             PC of the instruction being decoded
//   flush               squash all in-flight instructions
//   exc                 PC mux select for vec_pc (1-cycle pulse)
//   ret                 PC mux select for elr (1-cycle pulse)
//   vec_pc [64]         exception vector (constant VEC_ADDR)
//   elr [64]            exception link register
//   esr [4]             0001 IRQ, 0010 NAI, 0100 nested NAI
//   irq_src [3]         index of the IRQ being serviced
//   irq_ack [N_IRQ]     one-hot acknowledge, 1-cycle pulse on vector entry
//   in_handler          high from drain start until the return completes
module exc_ctrl #(
  parameter int unsigned N_IRQ        = 4,
  parameter int unsigned FLUSH_CYCLES = 3,
  parameter logic [63:0] VEC_ADDR     = 64'hD8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq_req,
  input  logic             irq_en,
  input  logic             nai,
  input  logic             eret,
  input  logic [63:0]      pc,
  output logic             flush,
  output logic             exc,
  output logic             ret,
  output logic [63:0]      vec_pc,
  output logic [63:0]      elr,
  output logic [3:0]       esr,
  output logic [2:0]       irq_src,
  output logic [N_IRQ-1:0] irq_ack,
  output logic             in_handler
);

  localparam int unsigned CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int unsigned ESR_W = 4;

  localparam logic [ESR_W-1:0] ESR_IRQ    = 4'b0001;
  localparam logic [ESR_W-1:0] ESR_NAI    = 4'b0010;
  localparam logic [ESR_W-1:0] ESR_NESTED = 4'b0100;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [N_IRQ-1:0] ACK_ONE  = N_IRQ'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_ENTER,
    S_HANDLER,
    S_RETURN
  } state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               flush_q;
  logic               exc_q;
  logic               ret_q;
  logic [63:0]        elr_q;
  logic [ESR_W-1:0]   esr_q;
  logic [2:0]         irq_src_q;
  logic [N_IRQ-1:0]   irq_ack_q;
  logic               in_handler_q;

  logic               irq_any;
  logic [2:0]         irq_low;

  // Lowest-index pending request wins; scan from the top so index 0 lands last.
  always_comb begin
    irq_low = 3'd0;
    for (int i = int'(N_IRQ) - 1; i >= 0; i--) begin
      if (irq_req[i]) irq_low = 3'(i);
    end
  end

  assign irq_any = irq_en & (|irq_req);

  // Sequencer: state, drain counter, captured ELR/ESR and registered pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      flush_q      <= 1'b0;
      exc_q        <= 1'b0;
      ret_q        <= 1'b0;
      elr_q        <= 64'd0;
      esr_q        <= '0;
      irq_src_q    <= 3'd0;
      irq_ack_q    <= '0;
      in_handler_q <= 1'b0;
    end else begin
      exc_q     <= 1'b0;
      ret_q     <= 1'b0;
      irq_ack_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (nai || irq_any) begin
            state_q      <= S_FLUSH;
            cnt_q        <= '0;
            flush_q      <= 1'b1;
            in_handler_q <= 1'b1;
            elr_q        <= pc;
            if (nai) begin
              esr_q <= ESR_NAI;
            end else begin
              esr_q     <= ESR_IRQ;
              irq_src_q <= irq_low;
            end
          end
        end
        S_FLUSH: begin
          // Selection is already latched; inputs are not looked at while draining.
          if (cnt_q == CNT_LAST) begin
            state_q <= S_ENTER;
            exc_q   <= 1'b1;
            if (esr_q == ESR_IRQ) irq_ack_q <= ACK_ONE << irq_src_q;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_ENTER: begin
          state_q <= S_HANDLER;
          flush_q <= 1'b0;
        end
        S_HANDLER: begin
          // ERet has priority over a fault in the same cycle.
          if (eret) begin
            state_q <= S_RETURN;
            ret_q   <= 1'b1;
            flush_q <= 1'b1;
          end else if (nai) begin
            state_q <= S_FLUSH;
            cnt_q   <= '0;
            flush_q <= 1'b1;
            esr_q   <= ESR_NESTED;
          end
        end
        S_RETURN: begin
          state_q      <= S_IDLE;
          flush_q      <= 1'b0;
          in_handler_q <= 1'b0;
        end
        default: begin
          state_q      <= S_IDLE;
          flush_q      <= 1'b0;
          in_handler_q <= 1'b0;
        end
      endcase
    end
  end

  assign flush      = flush_q;
  assign exc        = exc_q;
  assign ret        = ret_q;
  assign vec_pc     = VEC_ADDR;
  assign elr        = elr_q;
  assign esr        = esr_q;
  assign irq_src    = irq_src_q;
  assign irq_ack    = irq_ack_q;
  assign in_handler = in_handler_q;

endmodule
